// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI configuration register bank.
//   spi_state_e : frame phases (command bit, address field, data words)
//   CMD_WRITE   : value of the command bit that selects a write frame
//   addr_valid  : true when an address maps onto one of the registers
package spi_reg_pkg;

  typedef enum logic [1:0] {
    CMD  = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } spi_state_e;

  localparam logic CMD_WRITE = 1'b1;

  // Registers occupy addresses 1..num_regs; address 0 is reserved.
  function automatic logic addr_valid(input int unsigned addr, input int unsigned num_regs);
    return (addr != 0) && (addr <= num_regs);
  endfunction

endpackage

// File: rtl/spi_frame_ctrl.sv
// Frame sequencer for the SPI register bank: tracks the command/address/data
// phases, counts bits, captures the target address and (optionally) advances it
// after each data word.
// Configuration: define SPI_REG_BANK_AUTOINC_EN to increment the address after
// every data word (saturating, never wrapping back to 1).
// Ports:
//   spi_clk, rst   : clock and synchronous active-high reset
//   cs, pico_spi   : chip select (active-high) and serial data in
//   word_done      : this edge samples the last bit of a data word
//   addr_load      : this edge samples the last address bit
//   in_data        : frame is currently in the data phase
//   is_write       : command bit of the current frame was a write
//   cur_addr       : address targeted by the word in progress
//   next_addr      : address that will be targeted after this edge
module spi_frame_ctrl
  import spi_reg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              spi_clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              pico_spi,
  output logic              word_done,
  output logic              addr_load,
  output logic              in_data,
  output logic              is_write,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] next_addr
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = (MAX_W > 2) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;

  // NOTE: every output of this block is given a default before the case
  // statement, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    word_done = 1'b0;
    addr_load = 1'b0;
    if (!cs) begin
      state_d = CMD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CMD: begin
          wr_d    = (pico_spi == CMD_WRITE);
          state_d = ADDR;
          cnt_d   = '0;
        end
        ADDR: begin
          addr_d = {addr_q[ADDR_W-2:0], pico_spi};
          if (cnt_q == ADDR_LAST) begin
            state_d   = DATA;
            cnt_d     = '0;
            addr_load = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == DATA_LAST) begin
            word_done = 1'b1;
            cnt_d     = '0;
`ifdef SPI_REG_BANK_AUTOINC_EN
            // Saturate rather than wrap: the all-ones address is never a register.
            if (addr_q != '1) addr_d = addr_q + ADDR_W'(1);
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = CMD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state_q <= CMD;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

  assign in_data   = (state_q == DATA);
  assign is_write  = wr_q;
  assign cur_addr  = addr_q;
  assign next_addr = addr_d;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI slave configuration register bank. Deserialises command/address/data
// from pico_spi, holds NUM_REGS masked registers at addresses 1..NUM_REGS and
// serialises read-back on poci_spi, MSB first.
// Configuration: define SPI_REG_BANK_AUTOINC_EN for burst address auto-increment.
// Ports:
//   spi_clk    : sole clock, all logic on posedge
//   rst        : synchronous active-high reset
//   cs         : chip select, active-high; a frame runs while cs=1
//   pico_spi   : serial data in, MSB first
//   poci_spi   : serial data out, registered
//   regs       : register contents, reg k at [(k-1)*DATA_W +: DATA_W]
//   wr_strobe  : one-cycle pulse on bit k-1 after reg k is written
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 11,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS =
    {8'haa, 8'h00, 8'h01, 8'h00, 8'h00, 8'h04, 8'hff, 8'h03, 8'h00, 8'hff, 8'h3f},
  parameter logic [NUM_REGS*DATA_W-1:0] REG_MASK =
    {8'hff, 8'hff, 8'h01, 8'h3f, 8'h01, 8'h07, 8'hff, 8'h03, 8'h03, 8'hff, 8'h3f},
  parameter logic [NUM_REGS-1:0] PULSE_MASK = 11'b000_0000_0100
) (
  input  logic                         spi_clk,
  input  logic                         rst,
  input  logic                         cs,
  input  logic                         pico_spi,
  output logic                         poci_spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          wr_strobe
);

  logic              word_done, addr_load, in_data, is_write;
  logic [ADDR_W-1:0] cur_addr, next_addr;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-2:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   word_d;
  logic [DATA_W-1:0]   rd_shift_q, rd_shift_d, rd_val;
  logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
  logic                wr_en;

  spi_frame_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_frame_ctrl (
    .spi_clk   (spi_clk),
    .rst       (rst),
    .cs        (cs),
    .pico_spi  (pico_spi),
    .word_done (word_done),
    .addr_load (addr_load),
    .in_data   (in_data),
    .is_write  (is_write),
    .cur_addr  (cur_addr),
    .next_addr (next_addr)
  );

  always_comb begin
    // The completed word includes the bit being sampled on this edge.
    word_d      = {shift_q, pico_spi};
    shift_d     = word_d[DATA_W-2:0];
    wr_en       = word_done && is_write && addr_valid(32'(cur_addr), NUM_REGS);
    rd_val      = '0;
    wr_strobe_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      // Unmatched addresses (0, beyond NUM_REGS) leave rd_val at zero.
      if (next_addr == ADDR_W'(k + 1)) rd_val = regs_q[k];
      if (wr_en && (cur_addr == ADDR_W'(k + 1))) wr_strobe_d[k] = 1'b1;
    end

    rd_shift_d = rd_shift_q;
    if (!cs) begin
      rd_shift_d = '0;
    end else if (!is_write && (addr_load || word_done)) begin
      // Load on the edge that ends the address or the previous word, so the
      // MSB is already on poci_spi for the first data edge.
      rd_shift_d = rd_val;
    end else if (in_data) begin
      rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      // The register file is a handful of flops that must power up to known
      // configuration values, so every entry is reset.
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RST_VALS[k*DATA_W +: DATA_W] & REG_MASK[k*DATA_W +: DATA_W];
      end
      shift_q     <= '0;
      rd_shift_q  <= '0;
      wr_strobe_q <= '0;
    end else begin
      shift_q     <= shift_d;
      rd_shift_q  <= rd_shift_d;
      wr_strobe_q <= wr_strobe_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (!cs && PULSE_MASK[k]) begin
          regs_q[k] <= RST_VALS[k*DATA_W +: DATA_W] & REG_MASK[k*DATA_W +: DATA_W];
        end else if (wr_strobe_d[k]) begin
          regs_q[k] <= word_d & REG_MASK[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs[k*DATA_W +: DATA_W] = regs_q[k];
    end
  end

  assign poci_spi  = rd_shift_q[DATA_W-1];
  assign wr_strobe = wr_strobe_q;

endmodule
